pool_dp_multi: RTL and testbench

Parametrised 2x2 stride-2 pooling datapath: the next generation of the fixed three-unit pooling datapath. It adds a configurable unit count, run-time max/average mode, valid-qualified input with gap tolerance, odd-width column dropping and a row-pair completion pulse. It sits between a feature-map row buffer and the next layer's input FIFO. Each unit takes two vertically adjacent pixels per beat, and all units share one control path.

---
 rtl/pool_dp_multi_if.sv | 40 ++++
 rtl/pool_dp_multi.sv | 151 +++++++++++++++
 tb/tb_pool_dp_multi.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_dp_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : pool_dp_multi_if
//  Purpose  : Bundles the streaming control and data signals of the
//             multi-lane 2x2 pooling datapath.
//  Ports    : sync_clr  - synchronous counter/phase clear
//             in_valid  - beat qualifier shared by all lanes
//             pool_mode - 0 = max, 1 = average (latched at col 0 / ch 0)
//             data_in_A - top-row pixels, lane u at [u*DATA_WIDTH +: DATA_WIDTH]
//             data_in_B - bottom-row pixels, same packing
//             data_out  - pooled results, same packing
//             out_valid - data_out qualifier
//             row_done  - one-cycle pulse after the last beat of a row pair
//  Modports : master = upstream driver, slave = pooling datapath
//  Revision : 1.0 - initial release
// ============================================================================
interface pool_dp_multi_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_UNITS  = 3
);
  logic                            sync_clr;
  logic                            in_valid;
  logic                            pool_mode;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_in_A;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_in_B;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_out;
  logic                            out_valid;
  logic                            row_done;

  modport master (
    output sync_clr, in_valid, pool_mode, data_in_A, data_in_B,
    input  data_out, out_valid, row_done
  );

  modport slave (
    input  sync_clr, in_valid, pool_mode, data_in_A, data_in_B,
    output data_out, out_valid, row_done
  );
endinterface
`default_nettype wire

// File: rtl/pool_dp_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pool_dp_multi
//  Purpose  : Parametrised 2x2 stride-2 pooling datapath with NUM_UNITS
//             parallel lanes sharing one channel/column control path.
//             Even columns store a partial (max or A+B) per channel; odd
//             columns combine it with the new pair and emit a registered
//             result. An odd trailing column is accepted and discarded.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous, active-low reset
//             bus   - pool_dp_multi_if.slave (stream in / pooled stream out)
//  Revision : 1.0 - initial release
// ============================================================================
module pool_dp_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 7,
  parameter int IFM_DEPTH  = 16,
  parameter int NUM_UNITS  = 3
) (
  input  logic           clk,
  input  logic           reset,
  pool_dp_multi_if.slave bus
);

  localparam int CH_W  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam int COL_W = $clog2(IFM_SIZE);
  localparam bit ODD_SIZE = (IFM_SIZE % 2) == 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(IFM_DEPTH - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IFM_SIZE - 1);

  // Shared control path
  logic [CH_W-1:0]  ch;
  logic [COL_W-1:0] col;
  logic             mode_q;
  logic             accept;
  logic             first_beat;
  logic             last_ch;
  logic             last_col;
  logic             phase;
  logic             drop_col;
  logic             mode_eff;
  logic             buf_we;
  logic             out_fire;

  logic [NUM_UNITS*DATA_WIDTH-1:0] res_all;
  logic [NUM_UNITS*DATA_WIDTH-1:0] data_out_q;
  logic                            out_valid_q;
  logic                            row_done_q;

  // A clear on the same cycle as a valid beat drops that beat.
  assign accept     = bus.in_valid && !bus.sync_clr;
  assign first_beat = (ch == '0) && (col == '0);
  assign last_ch    = (ch == CH_LAST);
  assign last_col   = (col == COL_LAST);
  assign phase      = col[0];
  assign drop_col   = ODD_SIZE && last_col;
  // The col0/ch0 beat must already use the mode being latched on it.
  assign mode_eff   = first_beat ? bus.pool_mode : mode_q;
  assign buf_we     = accept && !phase && !drop_col;
  assign out_fire   = accept && phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch     <= '0;
      col    <= '0;
      mode_q <= 1'b0;
    end else if (bus.sync_clr) begin
      ch  <= '0;
      col <= '0;
    end else if (bus.in_valid) begin
      if (first_beat) begin
        mode_q <= bus.pool_mode;
      end
      if (last_ch) begin
        ch  <= '0;
        col <= last_col ? '0 : col + COL_W'(1);
      end else begin
        ch <= ch + CH_W'(1);
      end
    end
  end

  // Per-lane partial buffer and window arithmetic
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [DATA_WIDTH-1:0] max_ab;
    logic signed [DATA_WIDTH:0]   max_ab_x;
    logic signed [DATA_WIDTH:0]   sum_ab;
    logic signed [DATA_WIDTH:0]   wr_val;
    logic signed [DATA_WIDTH:0]   rd_val;
    logic signed [DATA_WIDTH+1:0] sum3;
    logic signed [DATA_WIDTH-1:0] max_res;
    logic signed [DATA_WIDTH-1:0] avg_res;
    logic signed [DATA_WIDTH:0]   pbuf [IFM_DEPTH];
    logic                         unused_lsb;

    assign a = bus.data_in_A[u*DATA_WIDTH +: DATA_WIDTH];
    assign b = bus.data_in_B[u*DATA_WIDTH +: DATA_WIDTH];

    assign max_ab   = (a > b) ? a : b;
    assign max_ab_x = {max_ab[DATA_WIDTH-1], max_ab};
    // One extra bit holds A+B of two full-range pixels exactly.
    assign sum_ab   = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    assign wr_val   = mode_eff ? sum_ab : max_ab_x;

    // Reads happen on odd columns and writes on even ones, so the same
    // entry is never read and written in one cycle.
    always_ff @(posedge clk) begin
      if (buf_we) begin
        pbuf[ch] <= wr_val;
      end
    end

    assign rd_val = pbuf[ch];

    // A stored max always fits DATA_WIDTH, so its low bits are the value.
    assign max_res = (rd_val > max_ab_x) ? rd_val[DATA_WIDTH-1:0] : max_ab;

    // Four-pixel sum needs two guard bits; dropping the two LSBs of the
    // signed sum is an arithmetic shift, i.e. floor toward -inf, and the
    // quotient always fits back into DATA_WIDTH.
    assign sum3 = {rd_val[DATA_WIDTH], rd_val}
                + {{2{a[DATA_WIDTH-1]}}, a}
                + {{2{b[DATA_WIDTH-1]}}, b};
    assign avg_res    = sum3[DATA_WIDTH+1:2];
    assign unused_lsb = ^sum3[1:0];

    assign res_all[u*DATA_WIDTH +: DATA_WIDTH] = mode_eff ? avg_res : max_res;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      out_valid_q <= out_fire;
      row_done_q  <= accept && last_col && last_ch;
      if (out_fire) begin
        data_out_q <= res_all;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.row_done  = row_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_dp_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool_dp_multi
//  Purpose  : Directed self-checking bench for pool_dp_multi
//             (DATA_WIDTH=8, IFM_SIZE=5, IFM_DEPTH=2, NUM_UNITS=2).
//  Ports    : none (top level)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pool_dp_multi;

  localparam int DW    = 8;
  localparam int SZ    = 5;
  localparam int DP    = 2;
  localparam int NU    = 2;
  localparam int BW    = NU * DW;
  localparam int BEATS = SZ * DP;
  localparam int NOUT  = (SZ / 2) * DP;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pool_dp_multi_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU)) bus ();

  pool_dp_multi #(
    .DATA_WIDTH (DW),
    .IFM_SIZE   (SZ),
    .IFM_DEPTH  (DP),
    .NUM_UNITS  (NU)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Row 0 is a max-mode row pair, row 1 an average-mode row pair.
  // Index: [row][beat][unit]; beat = col*DP + ch.
  int sa [2][BEATS][NU] = '{
    '{'{3,10}, '{-128,-5}, '{9,15}, '{-128,-7}, '{50,0},
      '{1,-1}, '{49,0}, '{3,-3}, '{127,127}, '{127,127}},
    '{'{127,127}, '{-1,-128}, '{127,127}, '{-1,-128}, '{10,-3},
      '{-128,5}, '{30,0}, '{0,1}, '{-100,-100}, '{-100,-100}}
  };
  int sb [2][BEATS][NU] = '{
    '{'{-7,20}, '{-128,-6}, '{-2,1}, '{-128,-9}, '{-50,0},
      '{2,-1}, '{48,1}, '{0,-2}, '{127,127}, '{127,127}},
    '{'{127,127}, '{-2,-128}, '{126,127}, '{-1,-128}, '{20,0},
      '{127,6}, '{40,0}, '{0,1}, '{-100,-100}, '{-100,-100}}
  };
  // Hand-computed results, index [row][output][unit].
  int exp_tab [2][NOUT][NU] = '{
    '{'{9,20}, '{-128,-5}, '{50,1}, '{3,-1}},
    '{'{126,127}, '{-2,-128}, '{25,-1}, '{-1,3}}
  };

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int q_cyc[$];
  int q_d0[$];
  int q_d1[$];
  int odd_cyc[$];
  int last_cyc = -1;
  int rd_cnt   = 0;
  int rd_cyc   = -1;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_d0.push_back(int'($signed(bus.data_out[DW-1:0])));
      q_d1.push_back(int'($signed(bus.data_out[2*DW-1:DW])));
    end
    if (bus.row_done === 1'b1) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_out(input int row, input int u, input int k);
    int col;
    int ch;
    int e;
    int o;
    int s;
    int m;
    col = 2 * (k / DP) + 1;
    ch  = k % DP;
    e   = (col - 1) * DP + ch;
    o   = col * DP + ch;
    if (row == 1) begin
      s = sa[row][e][u] + sb[row][e][u] + sa[row][o][u] + sb[row][o][u];
      return s >>> 2;
    end
    m = sa[row][e][u];
    if (sb[row][e][u] > m) m = sb[row][e][u];
    if (sa[row][o][u] > m) m = sa[row][o][u];
    if (sb[row][o][u] > m) m = sb[row][o][u];
    return m;
  endfunction

  task automatic clear_obs();
    q_cyc.delete();
    q_d0.delete();
    q_d1.delete();
    odd_cyc.delete();
    rd_cnt   = 0;
    rd_cyc   = -1;
    last_cyc = -1;
  endtask

  // Present one beat for the cycle following this negedge; the cycle number
  // recorded is the one in which the beat sits on the inputs.
  task automatic drive(input int row, input int idx, input bit valid,
                       input bit clr, input bit mode);
    @(negedge clk);
    bus.in_valid  = valid;
    bus.sync_clr  = clr;
    bus.pool_mode = mode;
    for (int u = 0; u < NU; u++) begin
      bus.data_in_A[u*DW +: DW] = sa[row][idx][u][DW-1:0];
      bus.data_in_B[u*DW +: DW] = sb[row][idx][u][DW-1:0];
    end
    if (valid && !clr) begin
      if (((idx / DP) % 2) == 1) odd_cyc.push_back(cyc);
      if (idx == BEATS - 1) last_cyc = cyc;
    end
  endtask

  task automatic idle(input bit mode);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.sync_clr  = 1'b0;
    bus.pool_mode = mode;
    bus.data_in_A = BW'($urandom);
    bus.data_in_B = BW'($urandom);
  endtask

  // flip: every beat after col0/ch0 (and every gap) carries the other mode.
  task automatic send_row(input int row, input bit gaps, input bit flip);
    bit m;
    for (int i = 0; i < BEATS; i++) begin
      m = (row == 1);
      if (flip && i != 0) m = !m;
      drive(row, i, 1'b1, 1'b0, m);
      if (gaps) idle(flip ? (row != 1) : (row == 1));
    end
  endtask

  task automatic check_outs(input int row, input int base, input bit use_model,
                            input string tag);
    int idx;
    int got;
    int exp;
    for (int k = 0; k < NOUT; k++) begin
      idx = base + k;
      for (int u = 0; u < NU; u++) begin
        exp = use_model ? ref_out(row, u, k) : exp_tab[row][k][u];
        if (idx < q_d0.size()) got = (u == 0) ? q_d0[idx] : q_d1[idx];
        else got = -999;
        check($sformatf("%s_out%0d_u%0d", tag, k, u), got, exp);
      end
      got = (idx < q_cyc.size()) ? q_cyc[idx] : -999;
      exp = (idx < odd_cyc.size()) ? odd_cyc[idx] + 1 : -1;
      check($sformatf("%s_lat%0d", tag, k), got, exp);
    end
  endtask

  task automatic check_row_done(input int n, input string tag);
    check({tag, "_row_done_cnt"}, rd_cnt, n);
    check({tag, "_row_done_cyc"}, rd_cyc, last_cyc + 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sync_clr  = 1'b0;
    bus.pool_mode = 1'b0;
    bus.data_in_A = '0;
    bus.data_in_B = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_row_done", int'(bus.row_done), 0);
    reset = 1'b1;

    // Max row pair followed immediately by an average row pair
    clear_obs();
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    check("b2b_count", q_cyc.size(), 2 * NOUT);
    check_outs(0, 0, 1'b0, "b2b_max");
    check_outs(1, NOUT, 1'b0, "b2b_avg");
    check_row_done(2, "b2b");

    // Gapped stream, mode flipped after the latch beat
    clear_obs();
    send_row(1, 1'b1, 1'b1);
    repeat (4) idle(1'b0);
    check("gap_avg_count", q_cyc.size(), NOUT);
    check_outs(1, 0, 1'b0, "gap_avg");
    check_row_done(1, "gap_avg");

    clear_obs();
    send_row(0, 1'b1, 1'b1);
    repeat (4) idle(1'b0);
    check("gap_max_count", q_cyc.size(), NOUT);
    check_outs(0, 0, 1'b0, "gap_max");
    check_row_done(1, "gap_max");

    // sync_clr on the col1/ch0 beat drops it; stream restarts at col0/ch0
    clear_obs();
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(0, 1, 1'b1, 1'b0, 1'b0);
    drive(0, 2, 1'b1, 1'b1, 1'b0);
    repeat (3) idle(1'b0);
    check("clr_no_out", q_cyc.size(), 0);
    check("clr_no_row_done", rd_cnt, 0);
    clear_obs();
    send_row(0, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    check("clr_after_count", q_cyc.size(), NOUT);
    check_outs(0, 0, 1'b0, "clr_after");
    check_row_done(1, "clr_after");

    // Asynchronous reset mid-row
    clear_obs();
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(0, 1, 1'b1, 1'b0, 1'b0);
    drive(0, 2, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("arst_pre_valid", int'(bus.out_valid), 1);
    check("arst_pre_u0", int'($signed(bus.data_out[DW-1:0])), 9);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    check("arst_data_out", int'(bus.data_out), 0);
    check("arst_out_valid", int'(bus.out_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_obs();
    send_row(1, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    check("arst_after_count", q_cyc.size(), NOUT);
    check_outs(1, 0, 1'b1, "arst_after");
    check_row_done(1, "arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
